// File: rtl/cdr_rx_ctrl_if.sv
// cdr_rx_ctrl_if: bit stream in, frame bytes and status out of the CDR receive controller
interface cdr_rx_ctrl_if;
  logic       i_start;
  logic       i_abort;
  logic       i_bit;
  logic       i_bit_vld;
  logic       o_cdr_en;
  logic       o_cdr_clr;
  logic [7:0] o_byte;
  logic       o_byte_vld;
  logic       o_sof;
  logic       o_eof;
  logic [6:0] o_len;
  logic       o_busy;
  logic       o_err;
  logic [1:0] o_err_code;
  modport master (
    output i_start, i_abort, i_bit, i_bit_vld,
    input  o_cdr_en, o_cdr_clr, o_byte, o_byte_vld, o_sof, o_eof, o_len, o_busy, o_err, o_err_code
  );
  modport slave (
    input  i_start, i_abort, i_bit, i_bit_vld,
    output o_cdr_en, o_cdr_clr, o_byte, o_byte_vld, o_sof, o_eof, o_len, o_busy, o_err, o_err_code
  );
endinterface

// File: rtl/cdr_rx_ctrl.sv
// cdr_rx_ctrl: preamble/SFD hunt, PHR length capture and payload byte assembly
module cdr_rx_ctrl #(
  parameter int         PREAMBLE_BITS = 32,
  parameter logic [7:0] SFD           = 8'hA7,
  parameter int         SFD_WIN       = 16,
  parameter int         TIMEOUT       = 255
) (
  input logic          i_clk,
  input logic          i_rst,
  cdr_rx_ctrl_if.slave bus
);
  localparam int ZW = $clog2(PREAMBLE_BITS + 1);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(SFD_WIN + 8);
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PHR, ST_PAYLOAD, ST_DONE, ST_ERR} state_t;
  state_t state, state_n;
  logic [ZW-1:0] zcnt;
  logic [GW-1:0] gap;
  logic [BW-1:0] bcnt;
  logic [6:0] sr;
  logic [6:0] nbytes;
  logic clr_q;
  logic [7:0] sh;
  logic rx, vld, accept, pre_done, sfd_hit, sfd_miss, byte_done, phr_zero, last, gap_to, strobe;
  // sr holds the upper seven bits of the window; sh is the window after shifting in the current bit
  assign sh        = {bus.i_bit, sr};
  assign rx        = state == ST_SFD || state == ST_PHR || state == ST_PAYLOAD;
  assign vld       = bus.i_bit_vld && !clr_q;
  assign accept    = state == ST_IDLE && bus.i_start && !bus.i_abort;
  assign pre_done  = state == ST_PREAMBLE && vld && !bus.i_bit && zcnt == ZW'(PREAMBLE_BITS - 1);
  assign sfd_hit   = state == ST_SFD && vld && sh == SFD;
  assign sfd_miss  = state == ST_SFD && vld && !sfd_hit && bcnt == BW'(SFD_WIN - 1);
  assign byte_done = (state == ST_PHR || state == ST_PAYLOAD) && vld && bcnt[2:0] == 3'd7;
  assign phr_zero  = state == ST_PHR && byte_done && sh[6:0] == 7'd0;
  assign last      = state == ST_PAYLOAD && byte_done && nbytes + 7'd1 == bus.o_len;
  assign gap_to    = rx && !bus.i_bit_vld && gap == GW'(TIMEOUT - 1);
  assign strobe    = state == ST_PAYLOAD && byte_done && !bus.i_abort;
  assign bus.o_cdr_en  = rx || state == ST_PREAMBLE;
  assign bus.o_cdr_clr = clr_q;
  assign bus.o_busy    = state != ST_IDLE;
  assign bus.o_err     = state == ST_ERR;
  // state register
  always_ff @(posedge i_clk)
    if (i_rst) state <= ST_IDLE;
    else state <= state_n;
  // next state; abort overrides every other transition
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     state_n = accept ? ST_PREAMBLE : ST_IDLE;
      ST_PREAMBLE: state_n = pre_done ? ST_SFD : ST_PREAMBLE;
      ST_SFD:      state_n = sfd_hit ? ST_PHR : (sfd_miss || gap_to) ? ST_ERR : ST_SFD;
      ST_PHR:      state_n = byte_done ? (phr_zero ? ST_ERR : ST_PAYLOAD) : gap_to ? ST_ERR : ST_PHR;
      ST_PAYLOAD:  state_n = last ? ST_DONE : gap_to ? ST_ERR : ST_PAYLOAD;
      default:     state_n = ST_IDLE;
    endcase
    if (bus.i_abort) state_n = ST_IDLE;
  end
  // counters, shift window and registered outputs
  always_ff @(posedge i_clk)
    if (i_rst) begin
      clr_q          <= 1'b0;
      zcnt           <= '0;
      gap            <= '0;
      bcnt           <= '0;
      sr             <= '0;
      nbytes         <= '0;
      bus.o_byte     <= '0;
      bus.o_byte_vld <= 1'b0;
      bus.o_sof      <= 1'b0;
      bus.o_eof      <= 1'b0;
      bus.o_len      <= '0;
      bus.o_err_code <= '0;
    end else begin
      clr_q          <= accept;
      zcnt           <= state != ST_PREAMBLE ? '0 : !vld ? zcnt : bus.i_bit ? '0 : zcnt + 1'b1;
      gap            <= (rx && !bus.i_bit_vld) ? gap + 1'b1 : '0;
      bcnt           <= !rx ? '0 : !vld ? bcnt : (sfd_hit || byte_done) ? '0 : bcnt + 1'b1;
      sr             <= !rx ? '0 : vld ? sh[7:1] : sr;
      nbytes         <= state != ST_PAYLOAD ? '0 : nbytes + 7'(byte_done);
      bus.o_byte_vld <= strobe;
      bus.o_sof      <= strobe && nbytes == 7'd0;
      bus.o_eof      <= strobe && last;
      bus.o_byte     <= strobe ? sh : bus.o_byte;
      bus.o_len      <= (byte_done && state == ST_PHR && !phr_zero && !bus.i_abort) ? sh[6:0] : bus.o_len;
      bus.o_err_code <= accept ? 2'd0 :
                        (state_n == ST_ERR && state != ST_ERR) ? (sfd_miss ? 2'd1 : phr_zero ? 2'd2 : 2'd3) :
                        bus.o_err_code;
    end
endmodule

// File: tb/tb_cdr_rx_ctrl.sv
// tb_cdr_rx_ctrl: scenario tasks with a byte scoreboard for cdr_rx_ctrl
module tb_cdr_rx_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  cdr_rx_ctrl_if bus();
  cdr_rx_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int checks = 0, errors = 0, strobes = 0, errs = 0, sofs = 0, eofs = 0;
  logic [9:0] q[$];
  logic [9:0] mexp;
  // every strobe is popped against the scoreboard; err pulses are tallied
  always @(negedge clk) begin
    if (bus.o_err) errs++;
    if (bus.o_byte_vld) begin
      strobes++;
      if (bus.o_sof) sofs++;
      if (bus.o_eof) eofs++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got byte=%h sof=%b eof=%b, required no strobe", bus.o_byte, bus.o_sof, bus.o_eof);
      end else begin
        mexp = q.pop_front();
        if ({bus.o_byte, bus.o_sof, bus.o_eof} !== mexp) begin
          errors++;
          $display("FAIL strobe_data: got byte=%h sof=%b eof=%b, required byte=%h sof=%b eof=%b",
                   bus.o_byte, bus.o_sof, bus.o_eof, mexp[9:2], mexp[1], mexp[0]);
        end
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bus.i_bit = b;
    bus.i_bit_vld = 1;
    tick();
    bus.i_bit_vld = 0;
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask
  task automatic zeros(input int n);
    repeat (n) send_bit(1'b0);
  endtask
  task automatic header(input logic [7:0] len);
    zeros(32);
    send_byte(8'hA7);
    send_byte(len);
  endtask
  task automatic payload(input logic [7:0] b, input logic first, input logic lst);
    q.push_back({b, first, lst});
    send_byte(b);
  endtask
  task automatic do_start();
    bus.i_start = 1;
    tick();
    bus.i_start = 0;
    checks++;
    if ({bus.o_cdr_clr, bus.o_busy, bus.o_cdr_en, bus.o_err_code} !== 5'b11100) begin
      errors++;
      $display("FAIL start: got clr/busy/en/code=%b, required 11100", {bus.o_cdr_clr, bus.o_busy, bus.o_cdr_en, bus.o_err_code});
    end
    tick();
    checks++;
    if (bus.o_cdr_clr !== 1'b0) begin
      errors++;
      $display("FAIL clr_pulse_len: got clr=%b in second cycle, required 0", bus.o_cdr_clr);
    end
  endtask
  task automatic check_reset_vals(input string name);
    checks++;
    if ({bus.o_cdr_en, bus.o_cdr_clr, bus.o_byte_vld, bus.o_sof, bus.o_eof, bus.o_err, bus.o_busy,
         bus.o_byte, bus.o_len, bus.o_err_code} !== 24'd0) begin
      errors++;
      $display("FAIL %s: got outputs=%h, required 000000", name,
               {bus.o_cdr_en, bus.o_cdr_clr, bus.o_byte_vld, bus.o_sof, bus.o_eof, bus.o_err, bus.o_busy,
                bus.o_byte, bus.o_len, bus.o_err_code});
    end
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    check_reset_vals("reset_state");
    rst = 0;
    tick();
  endtask
  task automatic test_frame();
    int s0, f0, l0;
    s0 = strobes; f0 = sofs; l0 = eofs;
    do_start();
    zeros(10);
    bus.i_start = 1;
    tick();
    bus.i_start = 0;
    checks++;
    if (bus.o_cdr_clr !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: got clr=%b busy=%b, required clr=0 busy=1", bus.o_cdr_clr, bus.o_busy);
    end
    zeros(22);
    send_byte(8'hA7);
    send_byte(8'h03);
    payload(8'h11, 1, 0);
    payload(8'h22, 0, 0);
    payload(8'h33, 0, 1);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_len !== 7'd3) begin
      errors++;
      $display("FAIL frame_len: got busy=%b len=%0d, required busy=1 len=3", bus.o_busy, bus.o_len);
    end
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || strobes - s0 != 3 || sofs - f0 != 1 || eofs - l0 != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL frame_end: got busy=%b strobes=%0d sof=%0d eof=%0d left=%0d, required 0 3 1 1 0",
               bus.o_busy, strobes - s0, sofs - f0, eofs - l0, q.size());
    end
  endtask
  task automatic test_preamble_one();
    int e0, s0;
    e0 = errs; s0 = strobes;
    do_start();
    zeros(20);
    send_bit(1'b1);
    zeros(31);
    checks++;
    if (errs != e0 || bus.o_err_code !== 2'd0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL preamble_reset: got errs=%0d code=%0d busy=%b, required 0 0 1", errs - e0, bus.o_err_code, bus.o_busy);
    end
    send_bit(1'b0);
    send_byte(8'hA7);
    send_byte(8'h01);
    payload(8'h5A, 1, 1);
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || strobes - s0 != 1 || errs != e0 || q.size() != 0) begin
      errors++;
      $display("FAIL preamble_frame: got busy=%b strobes=%0d errs=%0d left=%0d, required 0 1 0 0",
               bus.o_busy, strobes - s0, errs - e0, q.size());
    end
  endtask
  task automatic test_zero_len();
    int e0, s0;
    e0 = errs; s0 = strobes;
    do_start();
    header(8'h80);
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd2) begin
      errors++;
      $display("FAIL zero_len_err: got err=%b code=%0d, required err=1 code=2", bus.o_err, bus.o_err_code);
    end
    tick();
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_err_code !== 2'd2 || errs - e0 != 1 || strobes != s0) begin
      errors++;
      $display("FAIL zero_len_after: got err=%b busy=%b code=%0d pulses=%0d strobes=%0d, required 0 0 2 1 0",
               bus.o_err, bus.o_busy, bus.o_err_code, errs - e0, strobes - s0);
    end
  endtask
  task automatic test_timeout();
    int s0, l0, e0, c;
    s0 = strobes; l0 = eofs; e0 = errs; c = 0;
    do_start();
    repeat (300) tick();
    checks++;
    if (bus.o_busy !== 1'b1 || errs != e0 || bus.o_err_code !== 2'd0) begin
      errors++;
      $display("FAIL preamble_no_timeout: got busy=%b errs=%0d code=%0d, required 1 0 0", bus.o_busy, errs - e0, bus.o_err_code);
    end
    header(8'h04);
    payload(8'hA1, 1, 0);
    payload(8'hB2, 0, 0);
    for (int i = 1; i <= 300 && c == 0; i++) begin
      tick();
      if (bus.o_err) c = i;
    end
    checks++;
    if (c != 255 || bus.o_err_code !== 2'd3) begin
      errors++;
      $display("FAIL timeout: got err after %0d cycles code=%0d, required 255 cycles code=3", c, bus.o_err_code);
    end
    tick();
    checks++;
    if (strobes - s0 != 2 || eofs != l0 || q.size() != 0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_strobes: got strobes=%0d eof=%0d left=%0d busy=%b, required 2 0 0 0",
               strobes - s0, eofs - l0, q.size(), bus.o_busy);
    end
  endtask
  task automatic test_abort();
    int s0, e0;
    logic [7:0] v;
    s0 = strobes; e0 = errs; v = 8'h11;
    do_start();
    header(8'h02);
    for (int i = 0; i < 7; i++) send_bit(v[i]);
    bus.i_abort = 1;
    send_bit(v[7]);
    bus.i_abort = 0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_err !== 1'b0 || bus.o_byte_vld !== 1'b0) begin
      errors++;
      $display("FAIL abort: got busy=%b err=%b vld=%b, required 0 0 0", bus.o_busy, bus.o_err, bus.o_byte_vld);
    end
    tick();
    checks++;
    if (strobes != s0 || errs != e0) begin
      errors++;
      $display("FAIL abort_quiet: got strobes=%0d errs=%0d, required 0 0", strobes - s0, errs - e0);
    end
    do_start();
    bus.i_abort = 1;
    tick();
    bus.i_abort = 0;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_cdr_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b en=%b, required 0 0", bus.o_busy, bus.o_cdr_en);
    end
  endtask
  task automatic test_no_sfd();
    int n;
    n = 0;
    do_start();
    zeros(32);
    for (int i = 1; i <= 40 && n == 0; i++) begin
      send_bit(i[0]);
      if (bus.o_err) n = i;
    end
    checks++;
    if (n != 16 || bus.o_err_code !== 2'd1) begin
      errors++;
      $display("FAIL no_sfd: got err after %0d bits code=%0d, required 16 bits code=1", n, bus.o_err_code);
    end
    tick();
    tick();
    checks++;
    if (bus.o_err_code !== 2'd1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_code_hold: got code=%0d busy=%b, required code=1 busy=0", bus.o_err_code, bus.o_busy);
    end
  endtask
  task automatic test_reset_mid();
    int s0;
    logic [7:0] v;
    s0 = strobes; v = 8'h22;
    do_start();
    header(8'h03);
    payload(8'h11, 1, 0);
    for (int i = 0; i < 5; i++) send_bit(v[i]);
    rst = 1;
    tick();
    check_reset_vals("reset_mid");
    rst = 0;
    tick();
    checks++;
    if (strobes - s0 != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_strobes: got strobes=%0d left=%0d, required 1 0", strobes - s0, q.size());
    end
  endtask
  task automatic test_back_to_back();
    int s0;
    logic [7:0] a, b;
    s0 = strobes;
    for (int f = 0; f < 2; f++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_start();
      header(8'h82);
      payload(a, 1, 0);
      payload(b, 0, 1);
      tick();
    end
    checks++;
    if (strobes - s0 != 4 || q.size() != 0 || bus.o_busy !== 1'b0 || bus.o_len !== 7'd2) begin
      errors++;
      $display("FAIL back_to_back: got strobes=%0d left=%0d busy=%b len=%0d, required 4 0 0 2",
               strobes - s0, q.size(), bus.o_busy, bus.o_len);
    end
  endtask
  initial begin
    bus.i_start = 0;
    bus.i_abort = 0;
    bus.i_bit = 0;
    bus.i_bit_vld = 0;
    test_reset();
    test_frame();
    test_preamble_one();
    test_zero_len();
    test_timeout();
    test_abort();
    test_no_sfd();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdr_rx_ctrl.md
CDR_RX_CTRL -- requirements
Module: cdr_rx_ctrl

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 32: consecutive zero bits that qualify a preamble.
REQ-002 SHALL have parameter SFD, default 8'hA7: start-of-frame delimiter, received LSB first.
REQ-003 SHALL have parameter SFD_WIN, default 16: maximum bits searched for SFD after preamble qualifies.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum i_clk cycles allowed between bits from SFD search onward.
REQ-005 SHALL have port i_clk, input, 1: clock; all logic on rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_start, input, 1: arm receiver; accepted only in IDLE.
REQ-008 SHALL have port i_abort, input, 1: return to IDLE from any state.
REQ-009 SHALL have port i_bit, input, 1: recovered bit from CDR.
REQ-010 SHALL have port i_bit_vld, input, 1: i_bit qualifier, one-cycle pulse per bit.
REQ-011 SHALL have port o_cdr_en, output, 1: CDR enable.
REQ-012 SHALL have port o_cdr_clr, output, 1: one-cycle CDR restart pulse.
REQ-013 SHALL have port o_byte, output, 8: payload byte.
REQ-014 SHALL have port o_byte_vld / o_sof / o_eof, output, 1 each: byte strobe, first-byte marker, last-byte marker.
REQ-015 SHALL have port o_len, output, 7: PHR frame length.
REQ-016 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-017 SHALL have ports o_err (output, 1, one-cycle error pulse) and o_err_code (output, 2): 1=no SFD, 2=zero length, 3=timeout.

Function
REQ-018 SHALL implement states IDLE, PREAMBLE, SFD, PHR, PAYLOAD, DONE, ERR.
REQ-019 IDLE: i_start -> PREAMBLE; o_cdr_clr=1 for exactly the first PREAMBLE cycle; i_bit_vld in that cycle ignored; o_err_code cleared to 0.
REQ-020 o_cdr_en SHALL be 1 in PREAMBLE, SFD, PHR and PAYLOAD, else 0.
REQ-021 PREAMBLE: zero bit increments zero counter; one bit clears it; counter reaching PREAMBLE_BITS -> SFD with an all-zero 8-bit window; no timeout in PREAMBLE.
REQ-022 SFD: each bit shifts window as {i_bit, win[7:1]}; window==SFD after a shift -> PHR; SFD_WIN bits without match -> ERR code 1.
REQ-023 PHR: collect 8 bits LSB first; length = byte[6:0], bit 7 ignored; length 0 -> ERR code 2; else o_len <= length and state -> PAYLOAD.
REQ-024 PAYLOAD: bytes assembled LSB first; o_byte and o_byte_vld registered one cycle after the completing i_bit_vld; o_byte holds until next strobe.
REQ-025 o_sof SHALL accompany the first byte strobe; o_eof SHALL accompany the o_len-th strobe; length 1 asserts both on one strobe.
REQ-026 After the last byte: PAYLOAD -> DONE for one cycle -> IDLE.
REQ-027 Gap counter SHALL reset on every i_bit_vld and count otherwise in SFD, PHR and PAYLOAD; reaching TIMEOUT -> ERR code 3; i_bit_vld in the reaching cycle wins.
REQ-028 ERR: o_err=1 for one cycle; o_err_code held until next accepted i_start; then -> IDLE.
REQ-029 i_abort SHALL force IDLE next cycle without o_err and without pending strobes; i_abort wins over i_bit_vld, i_start and timeout in the same cycle.
REQ-030 i_start while o_busy=1 SHALL be ignored.

Reset
REQ-031 i_rst SHALL force IDLE and clear all counters and shift registers; o_cdr_en, o_cdr_clr, o_byte_vld, o_sof, o_eof, o_err, o_busy = 0; o_byte=0, o_len=0, o_err_code=0; mid-frame reset produces no strobes.

Verification
REQ-032 Start, 32 zeros, bits 1,1,1,0,0,1,0,1 (0xA7), PHR 0x03, payload 0x11,0x22,0x33 -> o_len=3, three strobes, o_sof with 0x11, o_eof with 0x33, o_busy low two cycles after last bit.
REQ-033 Preamble with a one at bit 20 -> no SFD entry until 32 further zeros; then a valid frame is received normally.
REQ-034 Valid preamble and SFD, PHR 0x80 -> ERR code 2, o_err pulse, no byte strobes.
REQ-035 Frame with length 4 stalled 256 cycles after second byte -> ERR code 3, exactly two strobes, no o_eof.
REQ-036 i_abort coincident with the bit completing payload byte 1 -> IDLE, no strobe, o_err=0; a following i_start gives an o_cdr_clr pulse.
REQ-037 40 bits of 0x55 pattern after preamble -> ERR code 1 after 16 bits; i_rst asserted mid-payload -> all outputs at reset values next cycle.
